com_bus_grant_ctrl: RTL and testbench

//  Consumer side of the common-bus request queue. Pops queued requester IDs (1..8) from the

---
 rtl/com_bus_pkg.sv | 33 +++
 rtl/com_bus_hold_timer.sv | 38 +++
 rtl/com_bus_grant_ctrl.sv | 171 +++++++++++++++++
 tb/tb_com_bus_grant_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/com_bus_pkg.sv
// Shared definitions for the common-bus request path.
// Used by the grant controller, the request FIFO and the bus monitors.
//   NUM_REQ   : number of bus requesters, IDs 1..NUM_REQ
//   ID_W      : width of a queued requester ID
//   ID_NONE   : ID value meaning "no entry / bus idle"
//   state_e   : grant controller FSM states
//   id2onehot : requester ID -> one-hot request/grant vector (0 for out-of-range IDs)
package com_bus_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 4;

  localparam logic [ID_W-1:0] ID_NONE = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    GRANT = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Bit i-1 is set for ID i; IDs 0 and >NUM_REQ give an all-zero vector.
  function automatic logic [NUM_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id == ID_W'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/com_bus_hold_timer.sv
// Grant hold timer.
// Counts grant cycles and flags when the current grant has been held for
// MAX_HOLD cycles (count value MAX_HOLD-1 in the last allowed cycle).
//   clk       : system clock
//   rst       : asynchronous active-high reset, count -> 0
//   clr_i     : synchronous clear, dominates en_i
//   en_i      : count one cycle
//   expired_o : count has reached MAX_HOLD-1
module com_bus_hold_timer #(
  parameter int MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Holds at LAST so the flag cannot wrap back to zero if the owner is slow to react.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/com_bus_grant_ctrl.sv
// Common-bus grant controller (consumer side of the request FIFO).
// Pops requester IDs in arrival order, grants the bus one-hot to that requester
// and holds the grant until the request drops or MAX_HOLD cycles elapse.
//   clk, rst     : system clock, asynchronous active-high reset
//   fifo_empty   : request FIFO empty flag
//   fifo_data    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : registered single-cycle pop strobe
//   bus_req      : live request lines, bit i-1 = ID i
//   bus_gnt      : registered one-hot grant, bit i-1 = ID i
//   gnt_id       : granted ID, 0 when idle
//   bus_busy     : any grant asserted
//   timeout_p    : pulse when a grant is force-revoked
//   bad_id_p     : pulse when a popped ID is 0 or >NUM_REQ
//   timeout_cnt  : saturating count of forced revokes
//   stale_cnt    : saturating count of popped IDs whose request was already low
module com_bus_grant_ctrl
  import com_bus_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic [ID_W-1:0]    fifo_data,
  output logic               fifo_rd_en,
  input  logic [NUM_REQ-1:0] bus_req,
  output logic [NUM_REQ-1:0] bus_gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               bus_busy,
  output logic               timeout_p,
  output logic               bad_id_p,
  output logic [CNT_W-1:0]   timeout_cnt,
  output logic [CNT_W-1:0]   stale_cnt
);

  state_e             state_q, state_d;
  logic               rd_en_q, rd_en_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               to_p_q, to_p_d;
  logic               bad_p_q, bad_p_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   stale_cnt_q, stale_cnt_d;
  logic               stale_inc, to_inc;

  logic [NUM_REQ-1:0] latch_oh;
  logic               id_valid;
  logic               req_live;
  logic               gnt_held;
  logic               tmr_clr, tmr_en, tmr_expired;

  assign latch_oh = id2onehot(fifo_data);
  assign id_valid = (fifo_data != ID_NONE) && (fifo_data <= ID_W'(NUM_REQ));
  // Masking with the one-hot vectors avoids indexing bus_req with an out-of-range ID.
  assign req_live = |(bus_req & latch_oh);
  assign gnt_held = |(bus_req & gnt_q);

  // Timer sits at zero everywhere except GRANT, so each grant starts a fresh count.
  assign tmr_clr = (state_q != GRANT);
  assign tmr_en  = (state_q == GRANT);

  com_bus_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      gnt_q       <= '0;
      gnt_id_q    <= ID_NONE;
      to_p_q      <= 1'b0;
      bad_p_q     <= 1'b0;
      to_cnt_q    <= '0;
      stale_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      to_p_q      <= to_p_d;
      bad_p_q     <= bad_p_d;
      to_cnt_q    <= to_cnt_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    to_p_d    = 1'b0;
    bad_p_d   = 1'b0;
    stale_inc = 1'b0;
    to_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = POP;
      end

      POP: begin
        state_d = LATCH;
      end

      LATCH: begin
        if (!id_valid) begin
          bad_p_d = 1'b1;
          state_d = IDLE;
        end else if (!req_live) begin
          stale_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          gnt_d    = latch_oh;
          gnt_id_d = fifo_data;
          state_d  = GRANT;
        end
      end

      GRANT: begin
        // Release is tested first so a release in the expiry cycle is not a timeout.
        if (!gnt_held) begin
          gnt_d    = '0;
          gnt_id_d = ID_NONE;
          state_d  = GAP;
        end else if (tmr_expired) begin
          gnt_d    = '0;
          gnt_id_d = ID_NONE;
          to_p_d   = 1'b1;
          to_inc   = 1'b1;
          state_d  = GAP;
        end
      end

      GAP: begin
        gnt_d    = '0;
        gnt_id_d = ID_NONE;
        state_d  = IDLE;
      end

      default: begin
        gnt_d    = '0;
        gnt_id_d = ID_NONE;
        state_d  = IDLE;
      end
    endcase

    // Strobe is registered: high exactly for the cycle spent in POP.
    rd_en_d = (state_d == POP);

    to_cnt_d    = (to_inc && (to_cnt_q != '1)) ? to_cnt_q + 1'b1 : to_cnt_q;
    stale_cnt_d = (stale_inc && (stale_cnt_q != '1)) ? stale_cnt_q + 1'b1 : stale_cnt_q;
  end

  assign fifo_rd_en  = rd_en_q;
  assign bus_gnt     = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign bus_busy    = |gnt_q;
  assign timeout_p   = to_p_q;
  assign bad_id_p    = bad_p_q;
  assign timeout_cnt = to_cnt_q;
  assign stale_cnt   = stale_cnt_q;

endmodule

// File: tb/tb_com_bus_grant_ctrl.sv
module tb_com_bus_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic [3:0] fifo_data = 4'd0;
  logic       fifo_rd_en;
  logic [7:0] bus_req = 8'd0;
  logic [7:0] bus_gnt;
  logic [3:0] gnt_id;
  logic       bus_busy, timeout_p, bad_id_p;
  logic [7:0] timeout_cnt, stale_cnt;

  com_bus_grant_ctrl #(.MAX_HOLD(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .bus_req(bus_req), .bus_gnt(bus_gnt), .gnt_id(gnt_id),
    .bus_busy(bus_busy), .timeout_p(timeout_p), .bad_id_p(bad_id_p),
    .timeout_cnt(timeout_cnt), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  // Request FIFO model: data appears the cycle after the pop strobe.
  logic [3:0] fifo_mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, underflow = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      else begin
        fifo_data <= fifo_mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int n_checks = 0, n_fail = 0;

  // Observation log: one entry per completed grant (id, cycles held, timeout pulse at release).
  int   ev_id[$], ev_len[$];
  bit   ev_to[$];
  logic [7:0] prev_gnt = 8'd0;
  int   cur_len = 0, cur_id = 0;
  int   hold_k [1:8];
  int   bad_pulses = 0, to_pulses = 0, inv_err = 0;

  task automatic push(input int id);
    fifo_mem[wr_ptr % 1024] = 4'(id);
    wr_ptr++;
  endtask

  task automatic clear_log();
    ev_id.delete(); ev_len.delete(); ev_to.delete();
  endtask

  // One clock: sample at the falling edge, log grant activity, play the requester role.
  task automatic step();
    logic [8:0] oh;
    @(negedge clk);
    if (rst) begin prev_gnt = 8'd0; cur_len = 0; return; end
    if (bus_busy !== (bus_gnt != 8'd0)) inv_err++;
    if (bus_gnt == 8'd0) begin
      if (gnt_id !== 4'd0) inv_err++;
      if (prev_gnt != 8'd0) begin
        ev_id.push_back(cur_id); ev_len.push_back(cur_len); ev_to.push_back(timeout_p);
      end
      cur_len = 0;
    end else begin
      oh = 9'd1 << gnt_id;
      if (!$onehot(bus_gnt) || bus_gnt !== oh[8:1]) inv_err++;
      if (timeout_p) inv_err++;
      if (prev_gnt == 8'd0) begin cur_len = 1; cur_id = int'(gnt_id); end
      else if (bus_gnt != prev_gnt) inv_err++;
      else cur_len++;
      if (cur_id >= 1 && cur_id <= 8 && hold_k[cur_id] == cur_len) bus_req[cur_id-1] = 1'b0;
    end
    if (timeout_p) to_pulses++;
    if (bad_id_p) bad_pulses++;
    prev_gnt = bus_gnt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 8; i++) hold_k[i] = 0;
    rst = 1'b1; bus_req = 8'd0;
    repeat (3) @(negedge clk);
    n_checks++; if ({fifo_rd_en, bus_gnt, gnt_id, bus_busy, timeout_p, bad_id_p, timeout_cnt, stale_cnt} !== 33'd0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", {fifo_rd_en, bus_gnt, gnt_id, bus_busy, timeout_p, bad_id_p, timeout_cnt, stale_cnt}); end
    rst = 1'b0;
    run(4);
    push(4);
    run(8);
    n_checks++; if (stale_cnt !== 8'd1) begin n_fail++; $display("FAIL pre_reset_stale: got %0d required 1", stale_cnt); end
    bus_req = 8'h04;
    push(3);
    run(5);
    n_checks++; if (bus_gnt !== 8'h04) begin n_fail++; $display("FAIL pre_reset_gnt: got %h required 04", bus_gnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus_gnt !== 8'h00) begin n_fail++; $display("FAIL async_reset_gnt: got %h required 00", bus_gnt); end
    n_checks++; if (gnt_id !== 4'd0 || bus_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_id: got id %0d busy %b required 0 0", gnt_id, bus_busy); end
    n_checks++; if (stale_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_cnt: got stale %0d timeout %0d required 0 0", stale_cnt, timeout_cnt); end
    step();
    rst = 1'b0; bus_req = 8'd0;
    clear_log();
    run(4);
  endtask

  task automatic test_single_grant();
    clear_log();
    bus_req = 8'h04;
    push(3);
    step();
    n_checks++; if (fifo_rd_en !== 1'b1 || bus_gnt !== 8'h00) begin n_fail++; $display("FAIL pop_strobe: got rd %b gnt %h required 1 00", fifo_rd_en, bus_gnt); end
    step();
    n_checks++; if (fifo_rd_en !== 1'b0 || bus_gnt !== 8'h00) begin n_fail++; $display("FAIL latch_cycle: got rd %b gnt %h required 0 00", fifo_rd_en, bus_gnt); end
    step();
    n_checks++; if (bus_gnt !== 8'h04 || gnt_id !== 4'd3 || bus_busy !== 1'b1) begin n_fail++; $display("FAIL grant_latency: got gnt %h id %0d busy %b required 04 3 1", bus_gnt, gnt_id, bus_busy); end
    step();
    bus_req = 8'h00;
    step();
    n_checks++; if (bus_gnt !== 8'h00 || gnt_id !== 4'd0) begin n_fail++; $display("FAIL release_drop: got gnt %h id %0d required 00 0", bus_gnt, gnt_id); end
    step();
    n_checks++; if (bus_gnt !== 8'h00 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL gap_cycle: got gnt %h rd %b required 00 0", bus_gnt, fifo_rd_en); end
    n_checks++; if (ev_len.size() != 1 || ev_len[0] != 2) begin n_fail++; $display("FAIL single_len: got %0d events required one of 2 cycles", ev_len.size()); end
    n_checks++; if (rd_ptr != wr_ptr) begin n_fail++; $display("FAIL single_pop: got rd_ptr %0d required %0d", rd_ptr, wr_ptr); end
    run(3);
  endtask

  task automatic test_back_to_back();
    int exp_ids [3] = '{5, 1, 8};
    clear_log();
    for (int i = 0; i < 3; i++) hold_k[exp_ids[i]] = 3;
    bus_req = 8'h91;
    for (int i = 0; i < 3; i++) push(exp_ids[i]);
    run(40);
    n_checks++; if (ev_id.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d grants required 3", ev_id.size()); end
    for (int i = 0; i < 3 && i < ev_id.size(); i++) begin
      n_checks++; if (ev_id[i] != exp_ids[i] || ev_len[i] != 3 || ev_to[i]) begin n_fail++; $display("FAIL b2b_grant%0d: got id %0d len %0d to %b required id %0d len 3 to 0", i, ev_id[i], ev_len[i], ev_to[i], exp_ids[i]); end
    end
    n_checks++; if (inv_err != 0) begin n_fail++; $display("FAIL b2b_overlap: got %0d grant violations required 0", inv_err); end
  endtask

  task automatic test_timeout();
    int p0;
    clear_log();
    p0 = to_pulses;
    hold_k[2] = 0;
    bus_req = 8'h02;
    push(2);
    run(75);
    n_checks++; if (ev_id.size() != 1 || ev_id[0] != 2 || ev_len[0] != 64 || !ev_to[0]) begin n_fail++; $display("FAIL timeout_grant: got %0d events len %0d required one id 2 len 64 with pulse", ev_id.size(), (ev_len.size() > 0) ? ev_len[0] : -1); end
    n_checks++; if (to_pulses - p0 != 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d pulse cycles required 1", to_pulses - p0); end
    n_checks++; if (timeout_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_cnt: got %0d required 1", timeout_cnt); end
    bus_req = 8'h00;
    run(2);
  endtask

  task automatic test_bad_stale();
    int b0;
    clear_log();
    b0 = bad_pulses;
    bus_req = 8'h00;
    push(0); push(9);
    run(12);
    n_checks++; if (bad_pulses - b0 != 2) begin n_fail++; $display("FAIL bad_id_pulses: got %0d required 2", bad_pulses - b0); end
    bus_req = 8'hF7;
    push(4);
    run(8);
    n_checks++; if (stale_cnt !== 8'd1) begin n_fail++; $display("FAIL stale_cnt: got %0d required 1", stale_cnt); end
    n_checks++; if (ev_id.size() != 0) begin n_fail++; $display("FAIL bad_stale_nogrant: got %0d grants required 0", ev_id.size()); end
    bus_req = 8'h00;
  endtask

  task automatic test_release_at_timeout();
    int p0;
    clear_log();
    p0 = to_pulses;
    hold_k[2] = 64; hold_k[6] = 2;
    bus_req = 8'h22;
    push(2); push(6);
    run(85);
    n_checks++; if (ev_id.size() != 2) begin n_fail++; $display("FAIL rel_to_count: got %0d grants required 2", ev_id.size()); end
    if (ev_id.size() == 2) begin
      n_checks++; if (ev_id[0] != 2 || ev_len[0] != 64 || ev_to[0]) begin n_fail++; $display("FAIL rel_to_first: got id %0d len %0d to %b required 2 64 0", ev_id[0], ev_len[0], ev_to[0]); end
      n_checks++; if (ev_id[1] != 6 || ev_len[1] != 2) begin n_fail++; $display("FAIL rel_to_next: got id %0d len %0d required 6 2", ev_id[1], ev_len[1]); end
    end
    n_checks++; if (timeout_cnt !== 8'd1 || to_pulses != p0) begin n_fail++; $display("FAIL rel_to_nocount: got cnt %0d pulses %0d required 1 0", timeout_cnt, to_pulses - p0); end
    bus_req = 8'h00;
  endtask

  task automatic test_random();
    int exp_stale = 1, exp_to = 1;
    for (int e = 0; e < 40; e++) begin
      int id, k, b0, kind;
      bit live;
      logic [7:0] other, m;
      clear_log();
      id    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8));
      live  = ($urandom_range(0, 3) != 0);
      k     = $urandom_range(1, 70);
      other = 8'($urandom_range(0, 255));
      m     = (id >= 1 && id <= 8) ? 8'(1 << (id - 1)) : 8'd0;
      if (m != 8'd0) hold_k[id] = k;
      bus_req = live ? (other | m) : (other & ~m);
      // 0 = bad ID, 1 = stale, 2 = granted for min(k, 64) cycles, timeout only if k > 64
      kind = (m == 8'd0) ? 0 : (live ? 2 : 1);
      if (kind == 1) exp_stale++;
      if (kind == 2 && k > 64) exp_to++;
      b0 = bad_pulses;
      push(id);
      run(72);
      n_checks++; if (ev_id.size() != ((kind == 2) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_grants: id %0d got %0d grants required %0d", e, id, ev_id.size(), (kind == 2) ? 1 : 0); end
      if (kind == 2 && ev_id.size() == 1) begin
        n_checks++; if (ev_id[0] != id || ev_len[0] != ((k > 64) ? 64 : k) || ev_to[0] != (k > 64)) begin n_fail++; $display("FAIL rnd%0d_hold: got id %0d len %0d to %b required id %0d len %0d to %b", e, ev_id[0], ev_len[0], ev_to[0], id, (k > 64) ? 64 : k, k > 64); end
      end
      n_checks++; if (bad_pulses - b0 != ((kind == 0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_bad: got %0d pulses required %0d", e, bad_pulses - b0, (kind == 0) ? 1 : 0); end
      n_checks++; if (stale_cnt !== 8'(exp_stale) || timeout_cnt !== 8'(exp_to)) begin n_fail++; $display("FAIL rnd%0d_cnts: got stale %0d timeout %0d required %0d %0d", e, stale_cnt, timeout_cnt, exp_stale, exp_to); end
    end
    bus_req = 8'h00;
  endtask

  task automatic test_saturation();
    logic [7:0] t0;
    clear_log();
    t0 = timeout_cnt;
    bus_req = 8'h00;
    for (int i = 0; i < 260; i++) push(7);
    run(260 * 3 + 20);
    n_checks++; if (stale_cnt !== 8'd255) begin n_fail++; $display("FAIL stale_saturate: got %0d required 255", stale_cnt); end
    n_checks++; if (timeout_cnt !== t0 || ev_id.size() != 0) begin n_fail++; $display("FAIL sat_side_effects: got timeout %0d grants %0d required %0d 0", timeout_cnt, ev_id.size(), t0); end
    n_checks++; if (rd_ptr != wr_ptr || underflow != 0) begin n_fail++; $display("FAIL fifo_drain: got rd %0d wr %0d underflow %0d", rd_ptr, wr_ptr, underflow); end
    n_checks++; if (inv_err != 0) begin n_fail++; $display("FAIL grant_invariants: got %0d violations required 0", inv_err); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_timeout();
    test_bad_stale();
    test_release_at_timeout();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "time limit");
  end

endmodule
